// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: control bundle and registered bundle.
// Imported by id_ex_stage and hazard_detect.
package id_ex_stage_pkg;

  localparam int REG_AW  = 5;
  localparam int FUNCT_W = 10;

  // {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t BUBBLE_CTRL = '0;

  // Non-data part of the ID/EX register
  typedef struct packed {
    logic               valid;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [REG_AW-1:0]  rd;
    logic [FUNCT_W-1:0] funct;
    ctrl_t              ctrl;
  } id_ex_t;

  function automatic id_ex_t bubble();
    id_ex_t b;
    b      = '0;
    b.ctrl = BUBBLE_CTRL;
    return b;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (combinational).
// Ports: ID valid/flush/rs1/rs2, EX valid/memread/rd -> stall_o.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic              valid_id_i,
  input  logic              flush_i,
  input  logic              valid_ex_i,
  input  logic              memread_ex_i,
  input  logic [REG_AW-1:0] rd_ex_i,
  input  logic [REG_AW-1:0] rs1_id_i,
  input  logic [REG_AW-1:0] rs2_id_i,
  output logic              stall_o
);

  logic rd_nz;
  logic match;

  assign rd_nz = |rd_ex_i;

  // Rs2 is compared even for I-type: stalls conservatively
  assign match = (rd_ex_i == rs1_id_i)
               | (rd_ex_i == rs2_id_i);

  // A flushed instruction must never hold the front end
  assign stall_o = valid_id_i & ~flush_i
                 & valid_ex_i & memread_ex_i
                 & rd_nz & match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble counter.
// Ports: ID fields in (*_ID_i), EX fields out (*_EX_o), Stall_o, BubbleCnt_o.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               Valid_ID_i,
  input  logic               Flush_i,
  input  logic [REG_AW-1:0]  Rs1_ID_i,
  input  logic [REG_AW-1:0]  Rs2_ID_i,
  input  logic [REG_AW-1:0]  Rd_ID_i,
  input  logic [DATA_W-1:0]  RS1data_ID_i,
  input  logic [DATA_W-1:0]  RS2data_ID_i,
  input  logic [DATA_W-1:0]  Imm_ID_i,
  input  logic [FUNCT_W-1:0] Funct_ID_i,
  input  logic [CTRL_W-1:0]  Ctrl_ID_i,
  output logic               Valid_EX_o,
  output logic [REG_AW-1:0]  Rs1_EX_o,
  output logic [REG_AW-1:0]  Rs2_EX_o,
  output logic [REG_AW-1:0]  Rd_EX_o,
  output logic [DATA_W-1:0]  RS1data_EX_o,
  output logic [DATA_W-1:0]  RS2data_EX_o,
  output logic [DATA_W-1:0]  Imm_EX_o,
  output logic [FUNCT_W-1:0] Funct_EX_o,
  output logic [CTRL_W-1:0]  Ctrl_EX_o,
  output logic               Stall_o,
  output logic [CNT_W-1:0]   BubbleCnt_o
);

  id_ex_t             ctl_d, ctl_q;
  logic [DATA_W-1:0]  d1_d, d1_q;
  logic [DATA_W-1:0]  d2_d, d2_q;
  logic [DATA_W-1:0]  imm_d, imm_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  logic stall;
  logic load;
  logic count;

  hazard_detect u_hazard (
    .valid_id_i   (Valid_ID_i),
    .flush_i      (Flush_i),
    .valid_ex_i   (ctl_q.valid),
    .memread_ex_i (ctl_q.ctrl.memread),
    .rd_ex_i      (ctl_q.rd),
    .rs1_id_i     (Rs1_ID_i),
    .rs2_id_i     (Rs2_ID_i),
    .stall_o      (stall)
  );

  assign load  = Valid_ID_i & ~stall & ~Flush_i;

  // Idle cycles also load a bubble but are not counted
  assign count = (stall | Flush_i) & Valid_ID_i;

  always_comb begin
    ctl_d = bubble();
    d1_d  = '0;
    d2_d  = '0;
    imm_d = '0;
    if (load) begin
      ctl_d.valid = 1'b1;
      ctl_d.rs1   = Rs1_ID_i;
      ctl_d.rs2   = Rs2_ID_i;
      ctl_d.rd    = Rd_ID_i;
      ctl_d.funct = Funct_ID_i;
      ctl_d.ctrl  = ctrl_t'(Ctrl_ID_i);
      d1_d        = RS1data_ID_i;
      d2_d        = RS2data_ID_i;
      imm_d       = Imm_ID_i;
    end
  end

  // Saturating: hold at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (count && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctl_q <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
      imm_q <= '0;
      cnt_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      imm_q <= imm_d;
      cnt_q <= cnt_d;
    end
  end

  assign Valid_EX_o   = ctl_q.valid;
  assign Rs1_EX_o     = ctl_q.rs1;
  assign Rs2_EX_o     = ctl_q.rs2;
  assign Rd_EX_o      = ctl_q.rd;
  assign Funct_EX_o   = ctl_q.funct;
  assign Ctrl_EX_o    = ctl_q.ctrl;
  assign RS1data_EX_o = d1_q;
  assign RS2data_EX_o = d2_q;
  assign Imm_EX_o     = imm_q;
  assign Stall_o      = stall;
  assign BubbleCnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, per-cycle model compare,
// plus literal checks on key points.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_id = 1'b0;
  logic        fl = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] d1 = '0, d2 = '0, im = '0;
  logic [9:0]  fn = '0;
  logic [6:0]  ct = '0;

  logic        v_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [31:0] d1_ex, d2_ex, im_ex;
  logic [9:0]  fn_ex;
  logic [6:0]  ct_ex;
  logic        stall;
  logic [15:0] cnt;

  int nchk = 0;
  int nerr = 0;

  localparam logic [6:0] C_ADD = 7'b1000010;
  localparam logic [6:0] C_LW  = 7'b1110100;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .Valid_ID_i(v_id), .Flush_i(fl),
    .Rs1_ID_i(rs1), .Rs2_ID_i(rs2), .Rd_ID_i(rd),
    .RS1data_ID_i(d1), .RS2data_ID_i(d2),
    .Imm_ID_i(im), .Funct_ID_i(fn), .Ctrl_ID_i(ct),
    .Valid_EX_o(v_ex), .Rs1_EX_o(rs1_ex),
    .Rs2_EX_o(rs2_ex), .Rd_EX_o(rd_ex),
    .RS1data_EX_o(d1_ex), .RS2data_EX_o(d2_ex),
    .Imm_EX_o(im_ex), .Funct_EX_o(fn_ex),
    .Ctrl_EX_o(ct_ex), .Stall_o(stall),
    .BubbleCnt_o(cnt)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: what instruction sits in EX, and how many bubbles so far
  typedef struct {
    bit          v;
    bit [4:0]    rs1, rs2, rd;
    bit [31:0]   d1, d2, im;
    bit [9:0]    fn;
    bit [6:0]    ct;
  } instr_t;

  instr_t m_ex = '{default: 0};
  int     m_cnt = 0;
  instr_t empty_i = '{default: 0};

  function automatic bit m_hazard();
    bit is_load;
    bit dep;
    is_load = m_ex.v && m_ex.ct[4] && m_ex.rd != 0;
    dep     = m_ex.rd == rs1 || m_ex.rd == rs2;
    return v_id && !fl && is_load && dep;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  <= empty_i;
      m_cnt <= 0;
    end else begin
      if (v_id && (fl || m_hazard())) begin
        m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
      if (v_id && !fl && !m_hazard()) begin
        m_ex <= '{1'b1, rs1, rs2, rd, d1, d2, im, fn, ct};
      end else begin
        m_ex <= empty_i;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", 64'(v_ex), 64'(m_ex.v));
    chk("rs1", 64'(rs1_ex), 64'(m_ex.rs1));
    chk("rs2", 64'(rs2_ex), 64'(m_ex.rs2));
    chk("rd", 64'(rd_ex), 64'(m_ex.rd));
    chk("d1", 64'(d1_ex), 64'(m_ex.d1));
    chk("d2", 64'(d2_ex), 64'(m_ex.d2));
    chk("imm", 64'(im_ex), 64'(m_ex.im));
    chk("funct", 64'(fn_ex), 64'(m_ex.fn));
    chk("ctrl", 64'(ct_ex), 64'(m_ex.ct));
    chk("stall", 64'(stall), 64'(m_hazard()));
    chk("cnt", 64'(cnt), 64'(m_cnt));
  end

  task automatic drive(input logic v, input logic f,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] r, input logic [6:0] c,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input logic [9:0] q);
    v_id = v; fl = f; rs1 = a; rs2 = b; rd = r;
    ct = c; d1 = x; d2 = y; im = z; fn = q;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    idle();
    step(); step();
    chk("rst_valid", 64'(v_ex), 0);
    chk("rst_cnt", 64'(cnt), 0);
    chk("rst_stall", 64'(stall), 0);
    rst_n = 1'b1;
    step();

    // pass-through: add x3,x1,x2
    drive(1, 0, 1, 2, 3, C_ADD, 32'h11, 32'h22, 32'h0, 10'h000);
    step();
    idle();
    #1;
    chk("t2_valid", 64'(v_ex), 1);
    chk("t2_rd", 64'(rd_ex), 3);
    chk("t2_d2", 64'(d2_ex), 64'h22);
    chk("t2_stall", 64'(stall), 0);

    // load-use
    drive(1, 0, 1, 0, 5, C_LW, 32'h100, 0, 32'h8, 10'h002);
    step();
    drive(1, 0, 5, 2, 6, C_ADD, 32'hA, 32'hB, 0, 10'h000);
    #1;
    chk("t3_stall", 64'(stall), 1);
    step();
    chk("t3_bub_ctrl", 64'(ct_ex), 0);
    chk("t3_bub_rd", 64'(rd_ex), 0);
    chk("t3_cnt", 64'(cnt), 1);
    chk("t3_stall_drop", 64'(stall), 0);
    step();
    idle();
    #1;
    chk("t3_rd", 64'(rd_ex), 6);
    chk("t3_valid", 64'(v_ex), 1);

    // non-hazards
    drive(1, 0, 1, 0, 0, C_LW, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 9, 8, C_ADD, 0, 0, 0, 0);
    #1;
    chk("t4_x0", 64'(stall), 0);
    drive(1, 0, 1, 0, 5, C_LW, 0, 0, 0, 0);
    step();
    drive(1, 0, 6, 7, 8, C_ADD, 0, 0, 0, 0);
    #1;
    chk("t4_nodep", 64'(stall), 0);
    drive(1, 0, 1, 2, 5, C_ADD, 0, 0, 0, 0);
    step();
    drive(1, 0, 5, 0, 8, C_ADD, 0, 0, 0, 0);
    #1;
    chk("t4_noload", 64'(stall), 0);

    // flush with hazard
    drive(1, 0, 1, 0, 5, C_LW, 0, 0, 0, 0);
    step();
    drive(1, 1, 5, 0, 8, C_ADD, 0, 0, 0, 0);
    #1;
    chk("t5_stall", 64'(stall), 0);
    step();
    idle();
    #1;
    chk("t5_valid", 64'(v_ex), 0);
    chk("t5_ctrl", 64'(ct_ex), 0);
    chk("t5_cnt", 64'(cnt), 2);

    // idle and invalid flush: no count
    step(); step();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    #1;
    chk("idle_cnt", 64'(cnt), 2);

    // reset mid-stall
    drive(1, 0, 1, 0, 5, C_LW, 0, 0, 0, 0);
    step();
    drive(1, 0, 5, 0, 8, C_ADD, 0, 0, 0, 0);
    #1;
    chk("t1_pre_stall", 64'(stall), 1);
    chk("t1_pre_valid", 64'(v_ex), 1);
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 64'(v_ex), 0);
    chk("t1_stall", 64'(stall), 0);
    chk("t1_rd", 64'(rd_ex), 0);
    chk("t1_ctrl", 64'(ct_ex), 0);
    chk("t1_cnt", 64'(cnt), 0);
    step();
    idle();
    rst_n = 1'b1;
    step();

    // saturation
    drive(1, 1, 0, 0, 1, C_ADD, 0, 0, 0, 0);
    repeat (65534) step();
    chk("t6_fffe", 64'(cnt), 64'hFFFE);
    repeat (3) step();
    chk("t6_ffff", 64'(cnt), 64'hFFFF);
    idle();
    step(); step();
    chk("t6_hold", 64'(cnt), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
